usb_input_assembler: RTL and testbench

- Receive direction of the USB sample path, running in the CLK domain.
- Accepts a byte stream that has already been synchronised into CLK, using a valid/ready handshake.
- Packs every 4 bytes into one complex sample {re[15:0], im[15:0]} and stores it in an internal word FIFO.
- Once a full frame of FRAME_LEN samples is buffered, streams that frame to the FFT input one sample per handshake, with frame_start/frame_last markers.

---
 rtl/usb_input_assembler.sv | 162 ++++++++++++++++
 tb/tb_usb_input_assembler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_input_assembler.sv
// USB receive-side sample assembler: packs four accepted bytes into one
// {re, im} word, buffers the words in a FIFO, and streams complete frames
// of FRAME_LEN samples to the FFT input using a valid/ready handshake.
module usb_input_assembler #(
    parameter  int FRAME_LEN  = 1024,
    parameter  int FIFO_DEPTH = 2048,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              fft_ready,
    output logic [15:0]       data_out_re,
    output logic [15:0]       data_out_im,
    output logic              data_out_valid,
    output logic              frame_start,
    output logic              frame_last,
    output logic [ADDR_W:0]   level,
    output logic              busy
);

    localparam int LVL_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [LVL_W-1:0] LVL_FRAME = LVL_W'(FRAME_LEN);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    logic [31:0]       head_q;
    logic [CNT_W-1:0]  sample_cnt;
    logic [LVL_W-1:0]  level_nxt;
    logic              accept, wr_en, out_hs;
    logic              load_head, load_first, load_next, end_frame;

    assign accept      = byte_valid && byte_ready;
    assign wr_en       = accept && (byte_cnt == 2'd3);
    assign out_hs      = data_out_valid && fft_ready;
    assign frame_start = data_out_valid && (sample_cnt == '0);
    assign frame_last  = data_out_valid && (sample_cnt == CNT_LAST);
    assign busy        = (state_q != IDLE);

    // Level: words written minus samples handed to the FFT.
    always_comb begin
        level_nxt = level;
        if (wr_en && !out_hs)
            level_nxt = level + 1'b1;
        else if (!wr_en && out_hs)
            level_nxt = level - 1'b1;
    end

    // Stream FSM next-state and datapath strobes.
    always_comb begin
        state_d    = state_q;
        load_head  = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        end_frame  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level >= LVL_FRAME) begin
                    state_d   = PREFETCH;
                    load_head = 1'b1;
                end
            end
            PREFETCH: begin
                state_d    = STREAM;
                load_first = 1'b1;
            end
            STREAM: begin
                if (out_hs) begin
                    if (frame_last) begin
                        state_d   = IDLE;
                        end_frame = 1'b1;
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream FSM state register.
    always_ff @(posedge CLK) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Byte side: packing, write pointer, level and registered ready.
    // byte_ready looks at the next level so a full FIFO blocks the very next byte.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            byte_cnt   <= '0;
            asm_q      <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            byte_ready <= 1'b0;
        end else begin
            level      <= level_nxt;
            byte_ready <= (level_nxt < LVL_FULL);
            if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
                case (byte_cnt)
                    2'd0:    asm_q[23:16] <= byte_in;
                    2'd1:    asm_q[15:8]  <= byte_in;
                    2'd2:    asm_q[7:0]   <= byte_in;
                    default: ;
                endcase
            end
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Word memory write; contents need no reset.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= {asm_q, byte_in};
    end

    // Read side: head prefetch, output register and sample counter.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            rd_ptr         <= '0;
            head_q         <= '0;
            data_out_re    <= '0;
            data_out_im    <= '0;
            data_out_valid <= 1'b0;
            sample_cnt     <= '0;
        end else begin
            if (load_head) begin
                head_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (load_first) begin
                {data_out_re, data_out_im} <= head_q;
                data_out_valid             <= 1'b1;
                sample_cnt                 <= '0;
            end
            if (load_next) begin
                {data_out_re, data_out_im} <= mem[rd_ptr];
                rd_ptr                     <= rd_ptr + 1'b1;
                sample_cnt                 <= sample_cnt + 1'b1;
            end
            if (end_frame) begin
                data_out_valid <= 1'b0;
                sample_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_input_assembler.sv
// Directed bench for usb_input_assembler with a word scoreboard: words are
// pushed as their fourth byte is accepted and popped on each output handshake.
module tb_usb_input_assembler;

    localparam int FL = 4;
    localparam int FD = 8;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        fft_ready = 1'b0;
    logic [15:0] data_out_re, data_out_im;
    logic        data_out_valid, frame_start, frame_last, busy;
    logic [3:0]  level;

    usb_input_assembler #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .fft_ready(fft_ready),
        .data_out_re(data_out_re), .data_out_im(data_out_im),
        .data_out_valid(data_out_valid), .frame_start(frame_start),
        .frame_last(frame_last), .level(level), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int          ncmp = 0, nfail = 0;
    logic [31:0] exp_q[$];
    int          lvl = 0, bcnt = 0, ocnt = 0, xfers = 0, cyc = 0;
    logic [23:0] asm_m = '0;
    logic        tog = 1'b0;
    logic [3:0]  pat = 4'b1001;
    logic        hold_p = 1'b0, gap_p = 1'b0;
    logic [31:0] held_d = '0;
    logic [1:0]  held_m = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: score handshakes seen before the edge, then check after it.
    task automatic tick();
        logic        hs_o, hs_i;
        logic [31:0] w;
        if (tog) fft_ready = pat[cyc % 4];
        cyc++;
        hs_o = reset && data_out_valid && fft_ready;
        hs_i = reset && byte_valid && byte_ready;
        if (hold_p) begin
            chk("hold_valid", {31'd0, data_out_valid}, 1);
            chk("hold_data", {data_out_re, data_out_im}, held_d);
            chk("hold_marks", {30'd0, frame_start, frame_last}, {30'd0, held_m});
            chk("hold_busy", {31'd0, busy}, 1);
        end
        if (gap_p) chk("gap_valid", {31'd0, data_out_valid}, 0);
        hold_p = reset && data_out_valid && !fft_ready;
        held_d = {data_out_re, data_out_im};
        held_m = {frame_start, frame_last};
        gap_p  = hs_o && frame_last;
        if (hs_o) begin
            chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("sample", {data_out_re, data_out_im}, w);
                chk("frame_start", {31'd0, frame_start}, {31'd0, ocnt == 0});
                chk("frame_last", {31'd0, frame_last}, {31'd0, ocnt == FL - 1});
            end
            ocnt = (ocnt + 1) % FL;
            xfers++;
            lvl--;
        end
        if (hs_i) begin
            case (bcnt)
                0: asm_m[23:16] = byte_in;
                1: asm_m[15:8]  = byte_in;
                2: asm_m[7:0]   = byte_in;
                default: begin
                    exp_q.push_back({asm_m, byte_in});
                    lvl++;
                end
            endcase
            bcnt = (bcnt + 1) % 4;
        end
        @(posedge CLK);
        #1;
        if (!reset) begin
            exp_q.delete();
            lvl = 0; bcnt = 0; ocnt = 0; hold_p = 1'b0; gap_p = 1'b0;
            chk("rst_valid", {31'd0, data_out_valid}, 0);
            chk("rst_level", {28'd0, level}, 0);
            chk("rst_ready", {31'd0, byte_ready}, 0);
            chk("rst_marks", {30'd0, frame_start, frame_last}, 0);
            chk("rst_data", {data_out_re, data_out_im}, 0);
            chk("rst_busy", {31'd0, busy}, 0);
        end else begin
            chk("level", {28'd0, level}, lvl);
            chk("byte_ready", {31'd0, byte_ready}, {31'd0, lvl < FD});
        end
    endtask

    task automatic send(input logic [7:0] b);
        int   g = 0;
        logic a;
        byte_in = b;
        byte_valid = 1'b1;
        do begin
            a = byte_ready && reset;
            tick();
            g++;
        end while (!a && g < 50);
        if (!a) chk("send_timeout", {31'd0, a}, 1);
    endtask

    task automatic send_word(input logic [15:0] re, input logic [15:0] im);
        send(re[15:8]); send(re[7:0]); send(im[15:8]); send(im[7:0]);
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_until(input int n, input int budget);
        int g = 0;
        byte_valid = 1'b0;
        while (xfers < n && g < budget) begin
            tick();
            g++;
        end
        chk("xfer_count", xfers, n);
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        xfers = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        xfers = 0;

        // Single word stays buffered, no frame starts.
        fft_ready = 1'b1;
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        byte_valid = 1'b0;
        chk("t1_level", {28'd0, level}, 1);
        chk("t1_ready", {31'd0, byte_ready}, 1);
        chk("t1_valid", {31'd0, data_out_valid}, 0);
        idle(4);
        chk("t1_valid_later", {31'd0, data_out_valid}, 0);

        // Full frame with fft_ready high: valid rises two edges after level hits FL.
        do_reset();
        fft_ready = 1'b1;
        for (int k = 0; k < 4; k++) send_word(16'(k), 16'(0 - k));
        chk("t2_valid_e0", {31'd0, data_out_valid}, 0);
        byte_valid = 1'b0;
        tick();
        chk("t2_valid_e1", {31'd0, data_out_valid}, 0);
        tick();
        chk("t2_valid_e2", {31'd0, data_out_valid}, 1);
        chk("t2_start", {31'd0, frame_start}, 1);
        run_until(4, 20);
        idle(2);
        chk("t2_level_end", {28'd0, level}, 0);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Backpressure pattern 1,0,0,1 on fft_ready.
        do_reset();
        tog = 1'b1;
        cyc = 0;
        for (int k = 0; k < 4; k++) send_word(16'h0010 + 16'(k), 16'h0020 + 16'(k));
        run_until(4, 40);
        idle(6);
        tog = 1'b0;
        chk("t3_xfers", xfers, 4);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Fill to capacity with fft_ready low, then drain two frames.
        do_reset();
        fft_ready = 1'b0;
        acc = 0;
        byte_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            byte_in = 8'(i * 7 + 3);
            if (byte_ready) acc++;
            tick();
        end
        chk("t4_accepted", acc, 32);
        chk("t4_ready_full", {31'd0, byte_ready}, 0);
        chk("t4_level_full", {28'd0, level}, 8);
        byte_valid = 1'b0;
        fft_ready = 1'b1;
        run_until(8, 60);
        idle(2);
        chk("t4_ready_back", {31'd0, byte_ready}, 1);
        chk("t4_level_end", {28'd0, level}, 0);

        // Partial word discarded by reset.
        do_reset();
        fft_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i));
        do_reset();
        for (int k = 0; k < 4; k++) send_word(16'h0100 + 16'(k), 16'h0200 + 16'(k));
        idle(1);
        chk("t5_level", {28'd0, level}, 4);
        fft_ready = 1'b1;
        run_until(4, 20);

        // Reset in the middle of a frame aborts it.
        do_reset();
        fft_ready = 1'b1;
        for (int k = 0; k < 4; k++) send_word(16'h0300 + 16'(k), 16'h0400 + 16'(k));
        run_until(2, 20);
        reset = 1'b0;
        tick();
        chk("t6_valid", {31'd0, data_out_valid}, 0);
        chk("t6_level", {28'd0, level}, 0);
        reset = 1'b1;
        idle(8);
        chk("t6_xfers", xfers, 2);
        chk("t6_valid_after", {31'd0, data_out_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
